// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_div(input funct3_e f);
        return f[2];
    endfunction

    function automatic logic a_is_signed(input funct3_e f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic b_is_signed(input funct3_e f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide,
// sign fix-up in a dedicated cycle, fixed 34-cycle latency.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = ex_muldiv_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  FlushE,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    output logic                  Busy,
    output logic                  StallReq,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);
    import ex_muldiv_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);

    state_e                    state, state_next;
    funct3_e                   op;
    logic                      neg_a, neg_b;
    logic [DATA_WIDTH-1:0]     a_mag, b_mag;
    logic [2*DATA_WIDTH-1:0]   acc;   // product, or {remainder, quotient}
    logic [CW-1:0]             cnt;
    logic                      accept;

    logic                      sgn_a, sgn_b;
    logic [DATA_WIDTH:0]       mul_sum, div_shift;
    logic [DATA_WIDTH-1:0]     div_diff;
    logic                      div_ge;
    logic [2*DATA_WIDTH-1:0]   prod_fix;
    logic [DATA_WIDTH-1:0]     quot_fix, rem_fix, fix_result;

    assign accept = (state == S_IDLE) && Start && !FlushE;
    assign sgn_a  = a_is_signed(funct3_e'(Funct3)) && Operand_A[DATA_WIDTH-1];
    assign sgn_b  = b_is_signed(funct3_e'(Funct3)) && Operand_B[DATA_WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        if (FlushE) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (Start) state_next = S_CALC;
                S_CALC: if (cnt == '0) state_next = S_FIX;
                S_FIX:  state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Busy     = (state == S_CALC) || (state == S_FIX);
        Done     = (state == S_DONE);
        StallReq = accept || Busy;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};
        div_shift = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag};
        div_diff  = div_shift[DATA_WIDTH-1:0] - b_mag;
    end

    // Divide-by-zero only needs the quotient forced; the remainder already equals A.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        if (b_mag == '0)
            quot_fix = '1;
        else
            quot_fix = (neg_a ^ neg_b) ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
        rem_fix = neg_a ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH];
        unique case (op)
            F3_MUL:                       fix_result = prod_fix[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            F3_DIV, F3_DIVU:              fix_result = quot_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= F3_MUL;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            cnt    <= '0;
            Result <= '0;
        end else if (accept) begin
            op    <= funct3_e'(Funct3);
            neg_a <= sgn_a;
            neg_b <= sgn_b;
            a_mag <= sgn_a ? -Operand_A : Operand_A;
            b_mag <= sgn_b ? -Operand_B : Operand_B;
            if (is_div(funct3_e'(Funct3)))
                acc <= {{DATA_WIDTH{1'b0}}, (sgn_a ? -Operand_A : Operand_A)};
            else
                acc <= {{DATA_WIDTH{1'b0}}, (sgn_b ? -Operand_B : Operand_B)};
            cnt <= CW'(DATA_WIDTH - 1);
        end else if (state == S_CALC) begin
            if (is_div(op))
                acc <= {(div_ge ? div_diff : div_shift[DATA_WIDTH-1:0]),
                        acc[DATA_WIDTH-2:0], div_ge};
            else
                acc <= {mul_sum, acc[DATA_WIDTH-1:1]};
            cnt <= cnt - 1'b1;
        end else if (state == S_FIX && !FlushE) begin
            Result <= fix_result;
        end
    end

endmodule
